// File: rtl/mips_dmem_copy_engine.sv
// Block copy / block fill master for the single-cycle MIPS data memory port.
// Copy alternates RD/WR cycles per word; fill writes one word per cycle.
module mips_dmem_copy_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  MODE,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
    input  logic [ADDR_WIDTH-1:0] DST_ADDR,
    input  logic [CNT_WIDTH-1:0]  WORD_CNT,
    input  logic [DATA_WIDTH-1:0] FILL_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  MEM_WR_EN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0]  ONE  = CNT_WIDTH'(1);

    state_t                state;
    logic                  fill_mode;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] fill_word;
    logic                  start_misaligned;

    assign start_misaligned = (DST_ADDR[1:0] != 2'b00) ||
                              (!MODE && (SRC_ADDR[1:0] != 2'b00));

    // Outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            fill_mode <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            fill_word <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            MEM_WR_EN <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    ERR  <= 1'b0;
                    if (START) begin
                        fill_mode <= MODE;
                        src_ptr   <= SRC_ADDR;
                        dst_ptr   <= DST_ADDR;
                        remaining <= WORD_CNT;
                        fill_word <= FILL_DATA;
                        if (start_misaligned || (WORD_CNT == '0)) begin
                            state <= S_FIN;
                            DONE  <= 1'b1;
                            ERR   <= start_misaligned;
                        end else if (!MODE) begin
                            state    <= S_RD;
                            BUSY     <= 1'b1;
                            MEM_ADDR <= SRC_ADDR;
                        end else begin
                            state     <= S_WR;
                            BUSY      <= 1'b1;
                            MEM_WR_EN <= 1'b1;
                            MEM_ADDR  <= DST_ADDR;
                            MEM_WDATA <= FILL_DATA;
                        end
                    end
                end
                S_RD: begin
                    src_ptr <= src_ptr + STEP;
                    if (ABORT) begin
                        state    <= S_FIN;
                        BUSY     <= 1'b0;
                        MEM_ADDR <= '0;
                        DONE     <= 1'b1;
                        ERR      <= 1'b1;
                    end else begin
                        // MEM_WDATA doubles as the copy word buffer.
                        state     <= S_WR;
                        MEM_WR_EN <= 1'b1;
                        MEM_ADDR  <= dst_ptr;
                        MEM_WDATA <= MEM_RDATA;
                    end
                end
                S_WR: begin
                    dst_ptr   <= dst_ptr + STEP;
                    remaining <= remaining - ONE;
                    if (ABORT || (remaining == ONE)) begin
                        state     <= S_FIN;
                        BUSY      <= 1'b0;
                        MEM_WR_EN <= 1'b0;
                        MEM_ADDR  <= '0;
                        DONE      <= 1'b1;
                        ERR       <= ABORT;
                    end else if (!fill_mode) begin
                        state     <= S_RD;
                        MEM_WR_EN <= 1'b0;
                        MEM_ADDR  <= src_ptr;
                    end else begin
                        MEM_ADDR  <= dst_ptr + STEP;
                        MEM_WDATA <= fill_word;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                    ERR   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_copy_engine.sv
// Bench for mips_dmem_copy_engine: 256-word memory model plus a word-level
// reference array updated from the copy/fill rules after every operation.
module tb_mips_dmem_copy_engine;

    logic        CLK = 1'b0;
    logic        RST, START, MODE, ABORT;
    logic [31:0] SRC_ADDR, DST_ADDR, FILL_DATA;
    logic [15:0] WORD_CNT;
    logic        BUSY, DONE, ERR, MEM_WR_EN;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mips_dmem_copy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .ABORT(ABORT),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .WORD_CNT(WORD_CNT),
        .FILL_DATA(FILL_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .MEM_WR_EN(MEM_WR_EN), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    // Memory aliases modulo 256 words, so address wrap maps onto the same array.
    assign MEM_RDATA = mem[MEM_ADDR[9:2]];
    always @(posedge CLK) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (MEM_WR_EN) mem[MEM_ADDR[9:2]] <= MEM_WDATA;
    end

    task automatic set_word(input int idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx[7:0]; pl_data = data;
        ref_mem[idx] = data;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic preload(input bit rand_fill);
        for (int i = 0; i < 256; i++) set_word(i, rand_fill ? $urandom : 32'h0);
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s mem: %0d words differ, first idx %0d got %h exp %h",
                     name, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic model_apply(input bit mode, input logic [31:0] src, input logic [31:0] dst,
                               input int nw, input logic [31:0] fill);
        int s = int'(src[9:2]);
        int d = int'(dst[9:2]);
        for (int i = 0; i < nw; i++)
            ref_mem[(d + i) % 256] = mode ? fill : ref_mem[(s + i) % 256];
    endtask

    // One operation: abort_k>0 raises ABORT during the k-th write cycle;
    // start_busy re-pulses START mid-operation and in the DONE cycle.
    task automatic run_op(input string name, input bit mode, input logic [31:0] src,
                          input logic [31:0] dst, input int cnt, input logic [31:0] fill,
                          input int abort_k, input bit start_busy);
        bit mis, exp_err, aborted, seen_done, alt_ok;
        int full, nw, exp_busy, busy, wr, done_cyc;
        mis      = (dst[1:0] != 0) || (!mode && src[1:0] != 0);
        full     = mis ? 0 : cnt;
        aborted  = (abort_k > 0) && (abort_k <= full);
        nw       = aborted ? abort_k : full;
        exp_err  = mis || aborted;
        exp_busy = mode ? nw : 2 * nw;
        busy = 0; wr = 0; done_cyc = -1; seen_done = 0; alt_ok = 1;

        START = 1'b1; MODE = mode; SRC_ADDR = src; DST_ADDR = dst;
        WORD_CNT = cnt[15:0]; FILL_DATA = fill;
        @(negedge CLK);
        START = 1'b0;
        for (int cyc = 0; cyc < 4 * cnt + 10; cyc++) begin
            if (DONE) begin
                seen_done = 1; done_cyc = cyc;
                checks++;
                if (ERR !== exp_err || BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_flags: ERR=%b BUSY=%b exp ERR=%b BUSY=0",
                             name, ERR, BUSY, exp_err);
                end
                break;
            end
            if (BUSY) busy++;
            if (MEM_WR_EN) wr++;
            if (!mode && BUSY && (MEM_WR_EN !== (cyc % 2 == 1))) alt_ok = 0;
            ABORT = (abort_k > 0) && MEM_WR_EN && (wr == abort_k);
            if (start_busy && cyc == 1) begin
                START = 1'b1; MODE = ~mode; DST_ADDR = 32'h0000_0300; WORD_CNT = 16'd5;
            end
            @(negedge CLK);
            ABORT = 1'b0; START = 1'b0;
        end

        checks++;
        if (!seen_done || done_cyc != exp_busy) begin
            errors++;
            $display("FAIL %s done_timing: seen=%0d cycle %0d exp cycle %0d",
                     name, seen_done, done_cyc, exp_busy);
        end
        checks++;
        if (busy != exp_busy || wr != nw) begin
            errors++;
            $display("FAIL %s counts: busy %0d wr %0d exp busy %0d wr %0d",
                     name, busy, wr, exp_busy, nw);
        end
        if (!mode) begin
            checks++;
            if (!alt_ok) begin
                errors++;
                $display("FAIL %s wr_alternation: MEM_WR_EN not on odd busy cycles", name);
            end
        end
        if (seen_done) begin
            if (start_busy) begin
                START = 1'b1; MODE = 1'b1; DST_ADDR = 32'h0000_0300; WORD_CNT = 16'd2;
            end
            @(negedge CLK);
            START = 1'b0;
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL %s post_done: DONE=%b BUSY=%b exp 0 0", name, DONE, BUSY);
            end
        end
        model_apply(mode, src, dst, nw, fill);
        check_mem(name);
    endtask

    task automatic test_reset;
        RST = 1'b1; START = 1'b0; MODE = 1'b0; ABORT = 1'b0;
        SRC_ADDR = '0; DST_ADDR = '0; WORD_CNT = '0; FILL_DATA = '0;
        @(negedge CLK); @(negedge CLK);
        checks++;
        if ({BUSY, DONE, ERR, MEM_WR_EN} !== 4'b0 || MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset: BUSY=%b DONE=%b ERR=%b WR=%b ADDR=%h WDATA=%h exp all 0",
                     BUSY, DONE, ERR, MEM_WR_EN, MEM_ADDR, MEM_WDATA);
        end
        preload(1'b0);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_fill;
        run_op("fill", 1'b1, 32'h0, 32'h40, 4, 32'hA5A5_A5A5, 0, 1'b0);
        checks++;
        if (mem[20] !== 32'h0 || mem[16] !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL fill_bounds: mem[0x50]=%h mem[0x40]=%h exp 0 and a5a5a5a5",
                     mem[20], mem[16]);
        end
    endtask

    task automatic test_copy;
        for (int i = 0; i < 4; i++) set_word(i, 32'(i + 1));
        run_op("copy", 1'b0, 32'h0, 32'h80, 4, 32'h0, 0, 1'b0);
        checks++;
        if (mem[32] !== 32'd1 || mem[35] !== 32'd4) begin
            errors++;
            $display("FAIL copy_words: mem[0x80]=%h mem[0x8c]=%h exp 1 and 4", mem[32], mem[35]);
        end
    endtask

    task automatic test_misaligned_zero;
        run_op("misaligned_dst", 1'b1, 32'h0, 32'h42, 3, 32'hDEAD_BEEF, 0, 1'b0);
        run_op("misaligned_src", 1'b0, 32'h1, 32'h40, 3, 32'h0, 0, 1'b0);
        run_op("fill_ignores_src", 1'b1, 32'h3, 32'h60, 2, 32'h1234_5678, 0, 1'b0);
        run_op("zero_count", 1'b0, 32'h0, 32'h80, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_abort;
        preload(1'b1);
        run_op("abort_copy", 1'b0, 32'h100, 32'h200, 8, 32'h0, 3, 1'b1);
        run_op("abort_fill_last", 1'b1, 32'h0, 32'h240, 2, 32'h5555_AAAA, 2, 1'b0);
    endtask

    task automatic test_overlap;
        for (int i = 0; i < 4; i++) set_word(i, 32'(10 + i));
        run_op("overlap", 1'b0, 32'h0, 32'h4, 3, 32'h0, 0, 1'b0);
        checks++;
        if (mem[1] !== 32'd10 || mem[2] !== 32'd10 || mem[3] !== 32'd10) begin
            errors++;
            $display("FAIL overlap_words: %0d %0d %0d exp 10 10 10", mem[1], mem[2], mem[3]);
        end
        run_op("same_addr", 1'b0, 32'h20, 32'h20, 3, 32'h0, 0, 1'b0);
    endtask

    task automatic test_wrap;
        run_op("wrap_fill", 1'b1, 32'h0, 32'hFFFF_FFF8, 4, 32'hC0DE_0001, 0, 1'b0);
        run_op("wrap_copy", 1'b0, 32'hFFFF_FFFC, 32'h0000_0300, 3, 32'h0, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int wr = 0;
        int late = 0;
        START = 1'b1; MODE = 1'b0; SRC_ADDR = 32'h100; DST_ADDR = 32'h200;
        WORD_CNT = 16'd8; FILL_DATA = '0;
        @(negedge CLK);
        START = 1'b0;
        for (int cyc = 0; cyc < 40 && wr < 2; cyc++) begin
            if (MEM_WR_EN) wr++;
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || MEM_WR_EN !== 1'b0 || DONE !== 1'b0 || MEM_ADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: BUSY=%b WR=%b DONE=%b ADDR=%h exp 0", BUSY, MEM_WR_EN, DONE, MEM_ADDR);
        end
        RST = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (DONE || MEM_WR_EN || BUSY) late++;
            @(negedge CLK);
        end
        checks++;
        if (late != 0 || wr != 2) begin
            errors++;
            $display("FAIL reset_quiet: %0d active cycles after reset, writes before %0d exp 0 and 2", late, wr);
        end
        model_apply(1'b0, 32'h100, 32'h200, 2, 32'h0);
        check_mem("reset_mid");
        run_op("fill_after_reset", 1'b1, 32'h0, 32'h3C0, 5, 32'h0F0F_F0F0, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            bit mode;
            logic [31:0] src, dst, fill;
            int cnt, ak;
            mode = $urandom_range(0, 1);
            src  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            dst  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) src[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) dst[1:0] = 2'($urandom_range(1, 3));
            cnt  = $urandom_range(0, 12);
            fill = $urandom;
            ak   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cnt + 2) : 0;
            run_op($sformatf("random%0d", n), mode, src, dst, cnt, fill, ak, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset;
        test_fill;
        test_copy;
        test_misaligned_zero;
        test_abort;
        test_overlap;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_dmem_copy_engine.md
Name: mips_dmem_copy_engine

Overview:
- Initiator-side master for the single-cycle MIPS data memory port.
- Performs block copy (memory to memory) or block fill (constant to memory) of N 32-bit words.
- Drives the memory's write-enable, word address and write-data pins, and consumes its combinational read-data output.
- Used for test/boot initialisation and bulk data moves while the core is held off the data-memory port (port muxing is external).

Parameters:
- ADDR_WIDTH, 32, byte-address width of the memory port
- DATA_WIDTH, 32, data word width
- CNT_WIDTH, 16, width of the word-count request field

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  synchronous reset, active-high
- START  input  1  request strobe; sampled only in IDLE
- MODE  input  1  0 = copy, 1 = fill; captured with START
- ABORT  input  1  terminate active operation
- SRC_ADDR  input  ADDR_WIDTH  copy source byte address; captured with START
- DST_ADDR  input  ADDR_WIDTH  destination byte address; captured with START
- WORD_CNT  input  CNT_WIDTH  number of words; captured with START
- FILL_DATA  input  DATA_WIDTH  fill value; captured with START
- BUSY  output  1  operation in progress
- DONE  output  1  one-cycle completion pulse
- ERR  output  1  valid only with DONE; 1 = aborted or misaligned
- MEM_WR_EN  output  1  to data memory WR_EN
- MEM_ADDR  output  ADDR_WIDTH  to data memory input_addr (byte address)
- MEM_WDATA  output  DATA_WIDTH  to data memory write_data
- MEM_RDATA  input  DATA_WIDTH  from data memory read_data (combinational)

Behaviour:
- Reset:
  - RST=1 at an edge forces state IDLE.
  - BUSY, DONE, ERR and MEM_WR_EN go to 0; MEM_ADDR and MEM_WDATA go to 0; internal counters clear.
  - Reset mid-operation stops immediately. No further writes occur and no DONE is issued.
- States: IDLE, RD, WR, FIN.
- Outputs are decoded from registered state and registers only; there are no combinational paths from inputs to outputs.
- IDLE:
  - BUSY=0, MEM_WR_EN=0, MEM_ADDR=0.
  - On START=1: capture MODE, SRC_ADDR, DST_ADDR, WORD_CNT and FILL_DATA, then:
    - Misaligned: DST_ADDR[1:0]!=0, or MODE=0 and SRC_ADDR[1:0]!=0 -> FIN with ERR=1. No memory access.
    - WORD_CNT=0 -> FIN with ERR=0. No memory access.
    - Otherwise MODE=0 -> RD; MODE=1 -> WR.
- RD (copy only):
  - BUSY=1, MEM_ADDR=src pointer, MEM_WR_EN=0.
  - At the edge, latch MEM_RDATA into the word buffer, src pointer += 4, go to WR.
- WR:
  - BUSY=1, MEM_ADDR=dst pointer, MEM_WR_EN=1.
  - MEM_WDATA = word buffer (copy) or FILL_DATA (fill).
  - At the edge: dst pointer += 4, remaining count -= 1.
  - If remaining count was 1 -> FIN; else RD (copy) or stay in WR (fill).
- FIN: BUSY=0, DONE=1, ERR as set; next state IDLE.
- Latency:
  - Copy: 2N busy cycles. Fill: N busy cycles.
  - DONE appears in the cycle after the last write cycle.
  - Error and zero-count cases: DONE appears one cycle after the START sample.
- Pointer wrap: src and dst pointers increment modulo 2^ADDR_WIDTH. Wrap-around is not an error.
- Overlap: copy always proceeds in ascending order.
  - DST>SRC with overlapping ranges propagates source data forward; this is defined behaviour, not an error.
  - DST=SRC rewrites identical data.
- START while BUSY=1 or in FIN is ignored; there is no queueing.
- ABORT in RD or WR: the current cycle's write, if any, still occurs at that edge; next state FIN with ERR=1. ABORT in IDLE or FIN has no effect.
- RST has priority over ABORT; ABORT has priority over normal sequencing.

Test Plan:
- Fill: preload memory 0s; START, MODE=1, DST=0x40, CNT=4, FILL=0xA5A5A5A5 -> words 0x40..0x4C = A5A5A5A5, 0x50 unchanged; 4 BUSY cycles; DONE=1, ERR=0 on the next cycle.
- Copy: mem[0x00..0x0C]=1,2,3,4; START, MODE=0, SRC=0x00, DST=0x80, CNT=4 -> mem[0x80..0x8C]=1,2,3,4; MEM_WR_EN high on alternate cycles, 8 BUSY cycles; DONE with ERR=0.
- Misaligned: DST=0x42, CNT=3 -> no MEM_WR_EN pulse; DONE=1, ERR=1 one cycle after START.
  - Zero count: CNT=0 -> DONE=1, ERR=0, no writes.
- Abort: copy CNT=8; assert ABORT in the 3rd WR cycle -> exactly 3 words written; DONE=1, ERR=1 next cycle; START during BUSY ignored.
- Overlap: mem[0..3 words]=10,11,12,13; copy SRC=0x0, DST=0x4, CNT=3 -> words 1..3 = 10,10,10.
- Reset: RST mid-copy after 2 writes -> next cycle BUSY=0, MEM_WR_EN=0, DONE never pulses; a subsequent fill works normally.
